note_score_tracker: RTL

//  Producer side of the score interface consumed by the high-score/display block.

---
 rtl/note_score_tracker.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/note_score_tracker.sv
// -----------------------------------------------------------------------------
// note_score_tracker
//
// Purpose:
//   Judges note arrivals against player button presses on 4 lanes while the
//   game is in PLAY mode. It accumulates a score, a hit count and a miss count
//   as 2-digit packed BCD values. Each nibble is one decimal digit, so the
//   7-seg lookups can use the values directly. On leaving PLAY the values
//   freeze, so the high-score/display block can capture them in FINISH.
//
// Optional feature (macro COMBO_BONUS_EN):
//   When defined, the block keeps an 8-bit saturating hit streak. While the
//   streak (before this cycle's update) is at least COMBO_LEN, every hit is
//   worth 2 points. When undefined, score always equals hits.
//
// Parameters:
//   WINDOW     hit window length in clk cycles (>= 1)
//   COMBO_LEN  streak length at which the combo bonus applies
//
// Ports:
//   clk         in   1  clock
//   n_rst       in   1  async reset, active-low
//   mode        in   3  3'b100 = PLAY, 3'b101 = FINISH, others idle
//   note_valid  in   4  per-lane 1-cycle pulse: note reached strike line
//   btn         in   4  per-lane button level (synchronised/debounced)
//   score       out  8  packed BCD score, 00..99
//   hits        out  8  packed BCD hit count, 00..99
//   misses      out  8  packed BCD miss count, 00..99
//   hit_pulse   out  1  strobe: at least one hit judged in the previous cycle
//   miss_pulse  out  1  strobe: at least one miss judged in the previous cycle
//
// Lane FSM:
//   state  | meaning
//   IDLE   | no note awaiting a press on this lane
//   OPEN   | note pending; cnt = cycles of the window left after this one
// -----------------------------------------------------------------------------
module note_score_tracker #(
    parameter int unsigned WINDOW    = 200,
    parameter int unsigned COMBO_LEN = 5
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] mode,
    input  logic [3:0] note_valid,
    input  logic [3:0] btn,
    output logic [7:0] score,
    output logic [7:0] hits,
    output logic [7:0] misses,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    localparam int unsigned CW = $clog2(WINDOW + 1);
    // The note cycle itself is the first window cycle, so OPEN is entered
    // with WINDOW-2 cycles still to go after the next one. A miss is then
    // judged in the window's last cycle (cnt == 0).
    localparam logic [CW-1:0] CNT_LOAD  = (WINDOW > 1) ? CW'(WINDOW - 2) : '0;
    localparam logic [2:0]    MODE_PLAY = 3'b100;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_OPEN = 1'b1
    } lane_state_t;

    lane_state_t     lane_q [4];
    lane_state_t     lane_d [4];
    logic [CW-1:0]   cnt_q  [4];
    logic [CW-1:0]   cnt_d  [4];

    logic [3:0] btn_q;
    logic [2:0] mode_q;
    logic [3:0] press;
    logic       play;
    logic       play_entry;
    logic [3:0] lane_hit;
    logic [3:0] lane_miss;
    logic [2:0] nh;
    logic [2:0] nm;
    logic [3:0] score_inc;

    assign press      = btn & ~btn_q;
    assign play       = (mode == MODE_PLAY);
    assign play_entry = play && (mode_q != MODE_PLAY);

    function automatic logic [7:0] bcd_add_sat(input logic [7:0] v, input logic [3:0] n);
        logic [7:0] bin;
        bin = 8'(v[7:4]) * 8'd10 + 8'(v[3:0]) + 8'(n);
        if (bin > 8'd99) begin
            bin = 8'd99;
        end
        return {4'(bin / 8'd10), 4'(bin % 8'd10)};
    endfunction

    // Lane state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= L_IDLE;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= lane_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Lane next-state and judging
    always_comb begin
        lane_hit  = '0;
        lane_miss = '0;
        for (int i = 0; i < 4; i++) begin
            lane_d[i] = lane_q[i];
            cnt_d[i]  = cnt_q[i];
            if (!play || play_entry) begin
                // Outside PLAY (and in the entry cycle) windows are dropped
                // silently; nothing is judged.
                lane_d[i] = L_IDLE;
                cnt_d[i]  = '0;
            end else begin
                unique case (lane_q[i])
                    L_IDLE: begin
                        if (note_valid[i]) begin
                            if (press[i]) begin
                                lane_hit[i] = 1'b1;
                            end else if (WINDOW == 1) begin
                                lane_miss[i] = 1'b1;
                            end else begin
                                lane_d[i] = L_OPEN;
                                cnt_d[i]  = CNT_LOAD;
                            end
                        end
                    end
                    L_OPEN: begin
                        if (press[i]) begin
                            lane_hit[i] = 1'b1;
                        end else if (note_valid[i] || cnt_q[i] == '0) begin
                            // A new note replaces an unpressed old one.
                            lane_miss[i] = 1'b1;
                        end
                        if (note_valid[i]) begin
                            lane_d[i] = L_OPEN;
                            cnt_d[i]  = CNT_LOAD;
                        end else if (press[i] || cnt_q[i] == '0) begin
                            lane_d[i] = L_IDLE;
                            cnt_d[i]  = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                    end
                    default: begin
                        lane_d[i] = L_IDLE;
                        cnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        nh = '0;
        nm = '0;
        for (int i = 0; i < 4; i++) begin
            nh = nh + {2'b00, lane_hit[i]};
            nm = nm + {2'b00, lane_miss[i]};
        end
    end

`ifdef COMBO_BONUS_EN
    logic [7:0] streak_q;
    logic [7:0] streak_d;
    logic [8:0] streak_sum;

    always_comb begin
        streak_sum = {1'b0, streak_q} + 9'(nh);
        if (nm != '0) begin
            streak_d = '0;
        end else if (streak_sum > 9'd255) begin
            streak_d = 8'hFF;
        end else begin
            streak_d = streak_sum[7:0];
        end
        // Bonus is decided on the streak as it stood before this cycle.
        if (32'(streak_q) >= COMBO_LEN) begin
            score_inc = {nh, 1'b0};
        end else begin
            score_inc = {1'b0, nh};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            streak_q <= '0;
        end else if (play_entry) begin
            streak_q <= '0;
        end else if (play) begin
            streak_q <= streak_d;
        end
    end
`else
    always_comb begin
        score_inc = {1'b0, nh};
    end
`endif

    // Counters, strobes and input history
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            btn_q      <= '0;
            mode_q     <= '0;
            score      <= '0;
            hits       <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            btn_q  <= btn;
            mode_q <= mode;
            if (play_entry) begin
                score      <= '0;
                hits       <= '0;
                misses     <= '0;
                hit_pulse  <= 1'b0;
                miss_pulse <= 1'b0;
            end else if (play) begin
                score      <= bcd_add_sat(score, score_inc);
                hits       <= bcd_add_sat(hits, {1'b0, nh});
                misses     <= bcd_add_sat(misses, {1'b0, nm});
                hit_pulse  <= (nh != '0);
                miss_pulse <= (nm != '0);
            end else begin
                hit_pulse  <= 1'b0;
                miss_pulse <= 1'b0;
            end
        end
    end

endmodule
